// File: rtl/btn_debounce_sync.sv
// btn_debounce_sync
//
// Input conditioning for raw push-buttons and slide switches. Each channel
// goes through a multi-flop synchroniser and then a tick-sampled debouncer.
// One prescaler is shared by all channels. The block delivers a clean
// registered level plus one-cycle rise and fall pulses per channel.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset (clears every flop)
//   btn_raw      [WIDTH-1:0] raw asynchronous inputs
//   btn_level    [WIDTH-1:0] debounced level per channel
//   btn_rise     [WIDTH-1:0] one-cycle pulse when btn_level goes 0->1
//   btn_fall     [WIDTH-1:0] one-cycle pulse when btn_level goes 1->0
//   sample_tick  one-cycle prescaler tick, period TICK_DIV
//
// Timing note: the channel counters update on the same clock edge that
// raises sample_tick. A newly accepted level therefore becomes visible in
// the same cycle as the tick that accepted it, and the rise or fall pulse
// appears in that same cycle.

module btn_debounce_sync #(
  parameter int WIDTH        = 2,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 10,
  parameter int SYNC_STAGES  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_rise,
  output logic [WIDTH-1:0] btn_fall,
  output logic             sample_tick
);

  localparam int PCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCNT_W = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STABLE_TICKS - 1);

  // ---------------------------------------------------------------------------
  // Synchroniser chain: stage 0 samples btn_raw, and the last stage feeds
  // the debouncer.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] sync_last;

  always_comb begin
    sync_d[0] = btn_raw;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Shared prescaler: pcnt wraps at TICK_DIV-1. tick_d is the registered
  // tick's next value, and it also serves as the channel update enable.
  // ---------------------------------------------------------------------------
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              tick_q, tick_d;

  always_comb begin
    tick_d = (pcnt_q == PCNT_LAST);
    pcnt_d = tick_d ? '0 : pcnt_q + PCNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= tick_d;
    end
  end

  assign sample_tick = tick_q;

  // ---------------------------------------------------------------------------
  // Per-channel debouncer. scnt == 0 means the channel is idle (the sampled
  // value agrees with the level, or no progress has been made). scnt > 0
  // means a differing value is pending. A tick that samples agreement drops
  // all progress, so only an unbroken run of STABLE_TICKS differing samples
  // changes the level.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic              level_q, level_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    always_comb begin
      scnt_d  = scnt_q;
      level_d = level_q;
      if (tick_d) begin
        if (sync_last[gi] == level_q) begin
          scnt_d = '0;
        end else if (scnt_q == SCNT_LAST) begin
          level_d = sync_last[gi];
          scnt_d  = '0;
        end else begin
          scnt_d = scnt_q + SCNT_W'(1);
        end
      end
      // Pulses are registered alongside the level, so each pulse lines up
      // with the first cycle that shows the new level.
      rise_d = level_d & ~level_q;
      fall_d = ~level_d & level_q;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        scnt_q  <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        scnt_q  <= scnt_d;
        level_q <= level_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    assign btn_level[gi] = level_q;
    assign btn_rise[gi]  = rise_q;
    assign btn_fall[gi]  = fall_q;
  end

endmodule

// File: tb/tb_btn_debounce_sync.sv
// Testbench for btn_debounce_sync (WIDTH=2, TICK_DIV=4, STABLE_TICKS=3,
// SYNC_STAGES=2).
//
// Cycle n is the state after the n-th clock edge that follows reset release.
// Raw input driven during cycle c reaches the debouncer at edge c+3. Level
// changes happen on tick edges (multiples of 4). Every expected pulse event
// is pushed into a queue when its stimulus is issued. A monitor pops and
// compares each pulse the DUT shows. On every other cycle it also checks
// that sample_tick follows the prescaler pattern and that btn_level holds.

module tb_btn_debounce_sync;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] btn_raw;
  logic [1:0] btn_level, btn_rise, btn_fall;
  logic       sample_tick;

  btn_debounce_sync #(
    .WIDTH(2), .TICK_DIV(4), .STABLE_TICKS(3), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_rise(btn_rise), .btn_fall(btn_fall),
    .sample_tick(sample_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] level;
  } ev_t;

  ev_t exp_q[$];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic rst_seen = 1'b1;
  logic mon_en = 1'b0;
  logic [1:0] last_level = 2'b00;

  always @(posedge clk) begin
    rst_seen <= reset;
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_seen) begin
        checks++;
        if ({btn_level, btn_rise, btn_fall, sample_tick} !== 7'b0) begin
          errors++;
          $display("FAIL reset_outputs: got level=%b rise=%b fall=%b tick=%b, want all 0",
                   btn_level, btn_rise, btn_fall, sample_tick);
        end
        last_level = 2'b00;
      end else begin
        checks++;
        if (sample_tick !== ((cyc % 4) == 0)) begin
          errors++;
          $display("FAIL sample_tick: cycle %0d got %b want %b", cyc, sample_tick, ((cyc % 4) == 0));
        end
        if ((btn_rise | btn_fall) !== 2'b00) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: cycle %0d rise=%b fall=%b level=%b, want no pulse",
                     cyc, btn_rise, btn_fall, btn_level);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (cyc != e.cyc || btn_rise !== e.rise || btn_fall !== e.fall || btn_level !== e.level) begin
              errors++;
              $display("FAIL pulse_event: got cycle=%0d rise=%b fall=%b level=%b, want cycle=%0d rise=%b fall=%b level=%b",
                       cyc, btn_rise, btn_fall, btn_level, e.cyc, e.rise, e.fall, e.level);
            end else begin
              $display("event ok: cycle=%0d rise=%b fall=%b level=%b", cyc, btn_rise, btn_fall, btn_level);
            end
            last_level = e.level;
          end
        end else begin
          checks++;
          if (btn_level !== last_level) begin
            errors++;
            $display("FAIL level_hold: cycle %0d got level=%b want %b", cyc, btn_level, last_level);
          end
        end
      end
    end
  end

  task automatic push_ev(input int c, input logic [1:0] r, input logic [1:0] f, input logic [1:0] l);
    ev_t e;
    e.cyc = c; e.rise = r; e.fall = f; e.level = l;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int n, input logic [1:0] raw);
    @(posedge clk); #2;
    reset = 1'b1;
    btn_raw = raw;
    repeat (n) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Advance to 2 time units after the edge that starts cycle c (bounded).
  task automatic wait_cyc(input int c);
    int budget;
    budget = 500;
    while (cyc != c && budget > 0) begin
      @(posedge clk); #2;
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc: cycle %0d never reached (at %0d)", c, cyc);
    end
  endtask

  initial begin
    reset = 1'b1;
    btn_raw = 2'b11;
    @(posedge clk);
    mon_en = 1'b1;

    // 1: inputs high through reset -> rise on both channels at the 3rd tick
    $display("scenario: held high through reset");
    do_reset(3, 2'b11);
    push_ev(12, 2'b11, 2'b00, 2'b11);
    wait_cyc(20);

    // 2: clean press on channel 0, then 4: release
    $display("scenario: press/release channel 0");
    do_reset(3, 2'b00);
    wait_cyc(5);
    btn_raw = 2'b01;                        // sampled at edges 8,12,16
    push_ev(16, 2'b01, 2'b00, 2'b01);
    wait_cyc(20);
    btn_raw = 2'b00;                        // sampled at edges 24,28,32
    push_ev(32, 2'b00, 2'b01, 2'b00);
    wait_cyc(40);

    // 3: bounce 6 high / 2 low; every other tick samples low -> no change
    $display("scenario: bouncing channel 0");
    do_reset(3, 2'b00);
    wait_cyc(7);
    for (int i = 0; i < 60; i++) begin
      btn_raw = {1'b0, ((i % 8) < 6)};
      @(posedge clk); #2;
    end
    btn_raw = 2'b00;
    wait_cyc(90);

    // 5: both channels step together
    $display("scenario: simultaneous step");
    do_reset(3, 2'b00);
    wait_cyc(5);
    btn_raw = 2'b11;
    push_ev(16, 2'b11, 2'b00, 2'b11);
    wait_cyc(24);

    // 6: reset after two ticks of progress -> full count restarts
    $display("scenario: reset mid-count");
    do_reset(3, 2'b10);
    wait_cyc(9);
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    push_ev(12, 2'b10, 2'b00, 2'b10);
    wait_cyc(20);

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: %0d expected pulse events never seen, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
